rvc_asap_i_mem_ctrl: RTL and testbench

- Parametrised instruction memory for the rvc_asap cores; next generation of the fixed 32-bit, sync-read, backdoor-loaded I_MEM.
- Adds configurable depth, width and read latency, a request/valid fetch handshake with pipeline flush, and a byte-enabled hardware write port so the program can be loaded without backdoor forces.
- Adds a power-on init sequencer that fills the array with a known word.
- Sits between the IF stage (fetch port) and the loader/debug master (write port).

---
 rtl/rvc_asap_i_mem_ctrl_if.sv | 28 ++
 rtl/rvc_asap_i_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_rvc_asap_i_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_i_mem_ctrl_if.sv
// Fetch and write-port bundle for rvc_asap_i_mem_ctrl.
// master = IF stage / loader side, slave = memory side.
interface rvc_asap_i_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic                  fetch_req;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  fetch_flush;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_W-1:0]     fetch_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  init_done;

  modport master (
    output fetch_req, fetch_addr, fetch_flush, wr_en, wr_addr, wr_data, wr_be,
    input  fetch_ready, fetch_valid, fetch_data, init_done
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_flush, wr_en, wr_addr, wr_data, wr_be,
    output fetch_ready, fetch_valid, fetch_data, init_done
  );
endinterface

// File: rtl/rvc_asap_i_mem_ctrl.sv
// rvc_asap instruction memory: parametrised depth/width, 1- or 2-cycle
// pipelined fetch with flush, byte-enabled write port, power-on fill.
// Optional macro RVC_I_MEM_BYPASS_EN: a same-edge write/fetch collision
// returns the merged (new) word instead of the old array word.
module rvc_asap_i_mem_ctrl #(
  parameter int unsigned       ADDR_W        = 10,
  parameter int unsigned       DATA_W        = 32,
  parameter int unsigned       RD_LAT        = 1,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = 32'h0000_0013
) (
  input  logic                 clock,
  input  logic                 rst_n,
  rvc_asap_i_mem_ctrl_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic                fetch_ready;
  logic                mem_fill;
  logic                accept;
  logic                wr_ok;
  logic [DATA_W-1:0]   rd_word;
  logic                v0_q;
  logic [DATA_W-1:0]   d0_q;
  logic                fv_q;
  logic [DATA_W-1:0]   fd_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign accept = bus.fetch_req && fetch_ready;
  assign wr_ok  = bus.wr_en && (state_q == ST_READY);

  // FSM next-state and fill control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    fetch_ready = 1'b0;
    mem_fill    = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_fill = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        fetch_ready = 1'b1;
        init_done_d = 1'b1;
      end
      default: state_d = ST_READY;
    endcase
  end

  // FSM state, fill counter and init_done registers.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= INIT_ON_RESET ? ST_INIT : ST_READY;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Array writes: fill word during INIT, byte-enabled writes in READY.
  always_ff @(posedge clock) begin
    if (rst_n) begin
      if (mem_fill) begin
        mem[cnt_q] <= INIT_VALUE;
      end else if (wr_ok) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
        end
      end
    end
  end

  // Word captured at accept; optionally merged with a colliding write.
  always_comb begin
    rd_word = mem[bus.fetch_addr];
`ifdef RVC_I_MEM_BYPASS_EN
    if (wr_ok && (bus.wr_addr == bus.fetch_addr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
`endif
  end

  // Accept stage: array sampled on the accepting edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      d0_q <= '0;
    end else begin
      v0_q <= accept;
      if (accept) d0_q <= rd_word;
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      // Output stage; flush kills the word still sitting in the accept stage.
      always_ff @(posedge clock) begin
        if (!rst_n) begin
          fv_q <= 1'b0;
          fd_q <= '0;
        end else begin
          fv_q <= v0_q && !bus.fetch_flush;
          if (v0_q && !bus.fetch_flush) fd_q <= d0_q;
        end
      end
    end else if (RD_LAT == 2) begin : g_lat2
      logic              v1_q;
      logic [DATA_W-1:0] d1_q;
      // Extra stage plus output stage; flush clears both in-flight bits.
      always_ff @(posedge clock) begin
        if (!rst_n) begin
          v1_q <= 1'b0;
          d1_q <= '0;
          fv_q <= 1'b0;
          fd_q <= '0;
        end else begin
          v1_q <= v0_q && !bus.fetch_flush;
          d1_q <= d0_q;
          fv_q <= v1_q && !bus.fetch_flush;
          if (v1_q && !bus.fetch_flush) fd_q <= d1_q;
        end
      end
    end else begin : g_bad_lat
      $error("rvc_asap_i_mem_ctrl: RD_LAT must be 1 or 2");
    end
  endgenerate

  assign bus.fetch_ready = fetch_ready;
  assign bus.fetch_valid = fv_q;
  assign bus.fetch_data  = fd_q;
  assign bus.init_done   = init_done_q;

endmodule

// File: tb/tb_rvc_asap_i_mem_ctrl.sv
// Bench for rvc_asap_i_mem_ctrl: RD_LAT=1 and RD_LAT=2 instances share one
// stimulus stream; a cycle-level model predicts both, plus directed literals.
module tb_rvc_asap_i_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [3:0]  f_addr;
  logic        flush;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  int n_checks = 0;
  int n_err    = 0;

  rvc_asap_i_mem_ctrl_if #(.ADDR_W(4), .DATA_W(32)) if1 ();
  rvc_asap_i_mem_ctrl_if #(.ADDR_W(4), .DATA_W(32)) if2 ();

  assign if1.fetch_req = req;    assign if2.fetch_req = req;
  assign if1.fetch_addr = f_addr; assign if2.fetch_addr = f_addr;
  assign if1.fetch_flush = flush; assign if2.fetch_flush = flush;
  assign if1.wr_en = wr_en;      assign if2.wr_en = wr_en;
  assign if1.wr_addr = wr_addr;  assign if2.wr_addr = wr_addr;
  assign if1.wr_data = wr_data;  assign if2.wr_data = wr_data;
  assign if1.wr_be = wr_be;      assign if2.wr_be = wr_be;

  rvc_asap_i_mem_ctrl #(
    .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0000_0013)
  ) u_lat1 (.clock(clk), .rst_n(rst_n), .bus(if1));

  rvc_asap_i_mem_ctrl #(
    .ADDR_W(4), .DATA_W(32), .RD_LAT(2), .INIT_ON_RESET(1'b1), .INIT_VALUE(32'h0000_0013)
  ) u_lat2 (.clock(clk), .rst_n(rst_n), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // ---------------- model ----------------
  // r counts edges with rst_n high since the last reset edge; the memory is
  // usable once 16 such edges have passed. Returns are scheduled by edge number.
  logic        started = 1'b0;
  int unsigned e = 0;
  int unsigned r = 0;
  logic [31:0] mem_m [16];
  logic        sched_v [2][64];
  logic [31:0] sched_d [2][64];
  logic        exp_v [2];
  logic [31:0] exp_d [2];
  logic        exp_rdy = 1'b0;

  initial begin
    logic        rdy, acc, wr;
    logic [31:0] word;
    for (int l = 0; l < 2; l++) begin
      for (int k = 0; k < 64; k++) sched_v[l][k] = 1'b0;
      exp_v[l] = 1'b0;
      exp_d[l] = '0;
    end
    forever begin
      @(posedge clk);
      e = e + 1;
      if (!rst_n) begin
        r = 0;
        started = 1'b1;
        for (int l = 0; l < 2; l++) begin
          for (int k = 0; k < 3; k++) sched_v[l][(e + k) % 64] = 1'b0;
          exp_v[l] = 1'b0;
          exp_d[l] = '0;
        end
      end else begin
        rdy = (r >= 16);
        if (r < 16) r = r + 1;
        if (r == 16 && !rdy) for (int k = 0; k < 16; k++) mem_m[k] = 32'h0000_0013;
        acc  = req && rdy;
        wr   = wr_en && rdy;
        word = mem_m[f_addr];
`ifdef RVC_I_MEM_BYPASS_EN
        if (wr && acc && wr_addr == f_addr) word = merge(word, wr_data, wr_be);
`endif
        for (int l = 0; l < 2; l++) begin
          if (flush) for (int k = 0; k < 3; k++) sched_v[l][(e + k) % 64] = 1'b0;
          if (sched_v[l][e % 64]) begin
            exp_v[l] = 1'b1;
            exp_d[l] = sched_d[l][e % 64];
            sched_v[l][e % 64] = 1'b0;
          end else begin
            exp_v[l] = 1'b0;
          end
          if (acc) begin
            sched_v[l][(e + l + 1) % 64] = 1'b1;
            sched_d[l][(e + l + 1) % 64] = word;
          end
        end
        if (wr) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_be);
      end
      exp_rdy = (r >= 16);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_valid1", 32'(if1.fetch_valid), 32'(exp_v[0]));
        chk("m_data1",  if1.fetch_data, exp_d[0]);
        chk("m_ready1", 32'(if1.fetch_ready), 32'(exp_rdy));
        chk("m_done1",  32'(if1.init_done), 32'(exp_rdy));
        chk("m_valid2", 32'(if2.fetch_valid), 32'(exp_v[1]));
        chk("m_data2",  if2.fetch_data, exp_d[1]);
        chk("m_ready2", 32'(if2.fetch_ready), 32'(exp_rdy));
        chk("m_done2",  32'(if2.init_done), 32'(exp_rdy));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  // Counts edges until init_done; fetches are requested throughout (must be
  // ignored) and optionally a write is issued mid-fill (must be lost).
  task automatic wait_init(input logic lost_wr, output int n);
    n = 0;
    while (!if1.init_done && n < 40) begin
      req = 1'b1; f_addr = 4'(n);
      if (lost_wr && n == 4) begin
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
      end else begin
        wr_en = 1'b0; wr_be = '0;
      end
      tick();
      n++;
    end
    idle();
  endtask

  initial begin
    int n;
    logic [31:0] col_exp;
    rst_n = 1'b0; f_addr = '0; wr_addr = '0; wr_data = '0;
    idle();
    tick(); tick(); tick();
    chk("rst_valid1", 32'(if1.fetch_valid), 32'h0);
    chk("rst_data1",  if1.fetch_data, 32'h0);
    chk("rst_done1",  32'(if1.init_done), 32'h0);
    chk("rst_ready1", 32'(if1.fetch_ready), 32'h0);
    chk("rst_valid2", 32'(if2.fetch_valid), 32'h0);

    // Power-on fill
    rst_n = 1'b1;
    wait_init(1'b0, n);
    chk("init_cycles", 32'(n), 32'd16);
    tick(); tick();

    // Every address reads the fill word
    for (int a = 0; a < 16; a++) begin
      req = 1'b1; f_addr = 4'(a);
      tick();
      if (a > 0) begin
        chk("nop_valid", 32'(if1.fetch_valid), 32'h1);
        chk("nop_data",  if1.fetch_data, 32'h0000_0013);
      end
    end
    idle(); tick(); tick(); tick();

    // Partial byte write, then fetch
    do_write(4'd3, 32'hAABB_CCDD, 4'b0101);
    req = 1'b1; f_addr = 4'd3;
    tick();
    idle();
    tick();
    chk("be_valid1", 32'(if1.fetch_valid), 32'h1);
    chk("be_data1",  if1.fetch_data, 32'h00BB_00DD);
    chk("be_early2", 32'(if2.fetch_valid), 32'h0);
    tick();
    chk("be_valid2", 32'(if2.fetch_valid), 32'h1);
    chk("be_data2",  if2.fetch_data, 32'h00BB_00DD);
    chk("be_drop1",  32'(if1.fetch_valid), 32'h0);
    tick();

    // Back-to-back fetches with hold after valid drops
    do_write(4'd0, 32'h11, 4'hF);
    do_write(4'd1, 32'h22, 4'hF);
    do_write(4'd2, 32'h33, 4'hF);
    req = 1'b1; f_addr = 4'd0; tick();
    f_addr = 4'd1; tick();
    chk("b2b_d0", if1.fetch_data, 32'h11);
    f_addr = 4'd2; tick();
    chk("b2b_v1", 32'(if1.fetch_valid), 32'h1);
    chk("b2b_d1", if1.fetch_data, 32'h22);
    idle(); tick();
    chk("b2b_v2", 32'(if1.fetch_valid), 32'h1);
    chk("b2b_d2", if1.fetch_data, 32'h33);
    tick();
    chk("hold_v", 32'(if1.fetch_valid), 32'h0);
    chk("hold_d", if1.fetch_data, 32'h33);
    tick(); tick();

    // Flush with redirect fetch (RD_LAT=2 instance)
    do_write(4'd5, 32'h55, 4'hF);
    req = 1'b1; f_addr = 4'd8; tick();
    f_addr = 4'd9; tick();
    flush = 1'b1; f_addr = 4'd5; tick();
    chk("fl_kill_a", 32'(if2.fetch_valid), 32'h0);
    idle(); tick();
    chk("fl_kill_b", 32'(if2.fetch_valid), 32'h0);
    chk("fl_hold",   if2.fetch_data, 32'h33);
    tick();
    chk("fl_redir_v", 32'(if2.fetch_valid), 32'h1);
    chk("fl_redir_d", if2.fetch_data, 32'h55);
    tick();
    chk("fl_after", 32'(if2.fetch_valid), 32'h0);
    tick();

    // Same-edge write/fetch collision at addr 7
`ifdef RVC_I_MEM_BYPASS_EN
    col_exp = 32'hDEAD_BEEF;
`else
    col_exp = 32'h0000_0013;
`endif
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
    req = 1'b1; f_addr = 4'd7;
    tick();
    idle(); tick();
    chk("col_d1", if1.fetch_data, col_exp);
    tick();
    chk("col_d2", if2.fetch_data, col_exp);
    req = 1'b1; f_addr = 4'd7; tick();
    idle(); tick();
    chk("col_later", if1.fetch_data, 32'hDEAD_BEEF);
    tick(); tick();

    // Reset in the middle of the fill, write during fill is lost
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      req = 1'b1; f_addr = 4'(i); tick();
    end
    idle();
    chk("mid_done", 32'(if1.init_done), 32'h0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("mid_rst_done", 32'(if1.init_done), 32'h0);
    wait_init(1'b1, n);
    chk("reinit_cycles", 32'(n), 32'd16);
    req = 1'b1; f_addr = 4'd2; tick();
    idle(); tick();
    chk("lost_wr_v", 32'(if1.fetch_valid), 32'h1);
    chk("lost_wr_d", if1.fetch_data, 32'h0000_0013);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
